// File: rtl/u_rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package u_rr_arb_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // Increment with an explicit wrap at n, so non-power-of-two sizes never overrun.
    function automatic int unsigned inc_mod(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/u_pri_enc.sv
// Lowest-set-bit finder: one-hot, binary index and any-set flag.
module u_pri_enc #(
    parameter  int unsigned W   = 4,
    localparam int unsigned W_W = $clog2(W)
) (
    input  logic [W-1:0]   vec,
    output logic [W-1:0]   onehot,
    output logic [W_W-1:0] idx,
    output logic           any
);

    logic found;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (vec[i] && !found) begin
                onehot[i] = 1'b1;
                idx       = W_W'(i);
                found     = 1'b1;
            end
        end
        any = |vec;
    end

endmodule

// File: rtl/u_rr_arb.sv
// Round-robin arbiter with a registered one-hot grant held until the last beat.
module u_rr_arb
    import u_rr_arb_pkg::*;
#(
    parameter  int unsigned N   = 4,
    localparam int unsigned N_W = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   i_req,
    input  logic           i_ack,
    input  logic           i_last,
    output logic           o_gnt_vld,
    output logic [N-1:0]   o_gnt,
    output logic [N_W-1:0] o_gnt_idx,
    output logic           o_busy
);

    state_t         state, state_nxt;
    logic [N_W-1:0] p, p_nxt, p_sel;
    logic [N-1:0]   gnt, gnt_nxt;
    logic [N_W-1:0] gnt_idx, gnt_idx_nxt;
    logic [N-1:0]   mask, hi;
    logic [N-1:0]   hi_oh, req_oh, win_oh;
    logic [N_W-1:0] hi_idx, req_idx, win_idx;
    logic           hi_any, req_any;
    logic           rel;

    assign rel = (state == GRANT) && i_ack && i_last;

    // On release the mask is built from the advanced pointer so the next grant lands in the same edge.
    always_comb begin
        p_sel = rel ? N_W'(inc_mod(32'(gnt_idx), N)) : p;
        mask  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask[i] = (i >= 32'(p_sel));
        end
        hi = i_req & mask;
    end

    u_pri_enc #(.W(N)) u_enc_hi (
        .vec    (hi),
        .onehot (hi_oh),
        .idx    (hi_idx),
        .any    (hi_any)
    );

    u_pri_enc #(.W(N)) u_enc_req (
        .vec    (i_req),
        .onehot (req_oh),
        .idx    (req_idx),
        .any    (req_any)
    );

    assign win_oh  = hi_any ? hi_oh  : req_oh;
    assign win_idx = hi_any ? hi_idx : req_idx;

    always_comb begin
        state_nxt   = state;
        p_nxt       = p;
        gnt_nxt     = gnt;
        gnt_idx_nxt = gnt_idx;
        case (state)
            IDLE: begin
                if (req_any) begin
                    gnt_nxt     = win_oh;
                    gnt_idx_nxt = win_idx;
                    state_nxt   = GRANT;
                end
            end
            GRANT: begin
                if (rel) begin
                    p_nxt = p_sel;
                    if (req_any) begin
                        gnt_nxt     = win_oh;
                        gnt_idx_nxt = win_idx;
                    end else begin
                        gnt_nxt     = '0;
                        gnt_idx_nxt = '0;
                        state_nxt   = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            p       <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
        end else begin
            state   <= state_nxt;
            p       <= p_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= gnt_idx_nxt;
        end
    end

    assign o_gnt     = gnt;
    assign o_gnt_idx = gnt_idx;
    assign o_gnt_vld = (state == GRANT);
    assign o_busy    = o_gnt_vld;

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(o_gnt));
    a_gnt_stable: assert property (@(posedge clk) disable iff (rst)
        (o_gnt_vld && !i_ack) |=> $stable(o_gnt));
    a_req_held: assert property (@(posedge clk) disable iff (rst)
        (o_gnt_vld && !(i_ack && i_last)) |-> ((i_req & o_gnt) != '0));
    a_ack_idle: assert property (@(posedge clk) disable iff (rst)
        !o_gnt_vld |-> !i_ack);
`endif

endmodule

// File: tb/tb_u_rr_arb.sv
// Bench for u_rr_arb: directed vector table, fairness windows, and random traffic vs a rotating-scan model.
module tb_u_rr_arb;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] i_req;
    logic         i_ack;
    logic         i_last;
    logic         o_gnt_vld;
    logic [N-1:0] o_gnt;
    logic [1:0]   o_gnt_idx;
    logic         o_busy;

    int n_cmp;
    int n_err;

    // Reference state: valid flag, granted index, highest-priority index
    logic m_vld;
    int   m_idx;
    int   m_p;

    u_rr_arb #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_ack     (i_ack),
        .i_last    (i_last),
        .o_gnt_vld (o_gnt_vld),
        .o_gnt     (o_gnt),
        .o_gnt_idx (o_gnt_idx),
        .o_busy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ack;
        logic       last;
        logic [3:0] gnt;
    } vec_t;

    vec_t tbl[33];

    function automatic int pick(input logic [N-1:0] rq, input int p);
        for (int k = 0; k < N; k++) begin
            if (rq[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_to_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
        return 0;
    endfunction

    function automatic void model_update(input logic r, input logic [N-1:0] rq,
                                         input logic a, input logic l);
        if (r) begin
            m_vld = 1'b0;
            m_idx = 0;
            m_p   = 0;
        end else if (!m_vld) begin
            if (rq != '0) begin
                m_idx = pick(rq, m_p);
                m_vld = 1'b1;
            end
        end else if (a && l) begin
            m_p = (m_idx + 1) % N;
            if (rq != '0) begin
                m_idx = pick(rq, m_p);
            end else begin
                m_vld = 1'b0;
                m_idx = 0;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq, input logic a, input logic l);
        rst    = r;
        i_req  = rq;
        i_ack  = a;
        i_last = l;
        @(posedge clk);
        model_update(r, rq, a, l);
        #1;
    endtask

    logic [N-1:0] cur_req;
    logic [N-1:0] nr;
    logic         ra, rl, rr;
    logic [N-1:0] exp_gnt;
    int           fidx[13];
    logic [N-1:0] seen;

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        m_vld  = 1'b0;
        m_idx  = 0;
        m_p    = 0;
        rst    = 1'b1;
        i_req  = '0;
        i_ack  = 1'b0;
        i_last = 1'b0;

        tbl[0]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0};
        tbl[1]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0};
        tbl[2]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0};
        tbl[3]  = '{1'b0, 4'hF, 1'b0, 1'b0, 4'h1};
        tbl[4]  = '{1'b0, 4'hF, 1'b1, 1'b1, 4'h2};
        tbl[5]  = '{1'b0, 4'hF, 1'b1, 1'b1, 4'h4};
        tbl[6]  = '{1'b0, 4'hF, 1'b1, 1'b1, 4'h8};
        tbl[7]  = '{1'b0, 4'hF, 1'b1, 1'b1, 4'h1};
        tbl[8]  = '{1'b0, 4'hF, 1'b1, 1'b1, 4'h2};
        tbl[9]  = '{1'b0, 4'hF, 1'b1, 1'b0, 4'h2};
        tbl[10] = '{1'b0, 4'hF, 1'b1, 1'b0, 4'h2};
        tbl[11] = '{1'b0, 4'hF, 1'b1, 1'b0, 4'h2};
        tbl[12] = '{1'b0, 4'hF, 1'b1, 1'b1, 4'h4};
        tbl[13] = '{1'b0, 4'h7, 1'b1, 1'b1, 4'h1};
        tbl[14] = '{1'b0, 4'h3, 1'b1, 1'b1, 4'h2};
        tbl[15] = '{1'b0, 4'h3, 1'b1, 1'b1, 4'h1};
        tbl[16] = '{1'b0, 4'h5, 1'b1, 1'b1, 4'h4};
        tbl[17] = '{1'b0, 4'h4, 1'b1, 1'b1, 4'h4};
        tbl[18] = '{1'b0, 4'h4, 1'b1, 1'b1, 4'h4};
        tbl[19] = '{1'b0, 4'h4, 1'b1, 1'b1, 4'h4};
        tbl[20] = '{1'b0, 4'hC, 1'b1, 1'b1, 4'h8};
        tbl[21] = '{1'b1, 4'h9, 1'b0, 1'b0, 4'h0};
        tbl[22] = '{1'b0, 4'h9, 1'b0, 1'b0, 4'h1};
        tbl[23] = '{1'b0, 4'h9, 1'b1, 1'b0, 4'h1};
        tbl[24] = '{1'b0, 4'h9, 1'b0, 1'b1, 4'h1};
        tbl[25] = '{1'b0, 4'h9, 1'b1, 1'b1, 4'h8};
        tbl[26] = '{1'b0, 4'h8, 1'b1, 1'b1, 4'h8};
        tbl[27] = '{1'b0, 4'h8, 1'b1, 1'b1, 4'h8};
        tbl[28] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h0};
        tbl[29] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
        tbl[30] = '{1'b0, 4'h4, 1'b0, 1'b0, 4'h4};
        tbl[31] = '{1'b0, 4'h2, 1'b1, 1'b1, 4'h2};
        tbl[32] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h0};

        for (int r = 0; r < 33; r++) begin
            step(tbl[r].rst, tbl[r].req, tbl[r].ack, tbl[r].last);
            check($sformatf("tbl%0d_gnt", r), 32'(o_gnt), 32'(tbl[r].gnt));
            check($sformatf("tbl%0d_vld", r), 32'(o_gnt_vld), 32'(|tbl[r].gnt));
            check($sformatf("tbl%0d_busy", r), 32'(o_busy), 32'(|tbl[r].gnt));
            if (tbl[r].gnt != '0)
                check($sformatf("tbl%0d_idx", r), 32'(o_gnt_idx), 32'(onehot_to_idx(tbl[r].gnt)));
        end

        // Fairness: every window of N consecutive single-beat grants covers all requesters once
        step(1'b1, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'hF, 1'b0, 1'b0);
        fidx[0] = int'(o_gnt_idx);
        for (int g = 1; g < 13; g++) begin
            step(1'b0, 4'hF, 1'b1, 1'b1);
            fidx[g] = int'(o_gnt_idx);
        end
        for (int w = 0; w + N <= 13; w++) begin
            seen = '0;
            for (int k = 0; k < N; k++) seen[fidx[w + k]] = 1'b1;
            check($sformatf("fair_win%0d", w), 32'(seen), 32'hF);
        end

        // Random legal traffic checked against the rotating-scan model
        cur_req = '0;
        step(1'b1, '0, 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            rr = ($urandom_range(0, 149) == 0);
            ra = m_vld ? ($urandom_range(0, 9) < 6) : 1'b0;
            rl = $urandom_range(0, 1);
            for (int i = 0; i < N; i++) begin
                if (m_vld && i == m_idx)
                    nr[i] = (ra && rl) ? 1'($urandom_range(0, 1)) : 1'b1;
                else if (cur_req[i])
                    nr[i] = ($urandom_range(0, 4) != 0);
                else
                    nr[i] = ($urandom_range(0, 2) == 0);
            end
            cur_req = nr;
            step(rr, nr, ra, rl);
            exp_gnt = m_vld ? (N'(1) << m_idx) : '0;
            check($sformatf("rnd%0d_gnt", c), 32'(o_gnt), 32'(exp_gnt));
            check($sformatf("rnd%0d_vld", c), 32'(o_gnt_vld), 32'(m_vld));
            if (m_vld)
                check($sformatf("rnd%0d_idx", c), 32'(o_gnt_idx), 32'(m_idx));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
